// File: rtl/wb_dbg_master.sv
// wb_dbg_master
//   Byte-stream driven Wishbone master. Host software sends command frames
//   over a serial byte channel; each frame runs one 32-bit Wishbone cycle and
//   the result or status goes back on the same channel.
//     Write frame : 'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> 0x06 on ack
//     Read frame  : 'R'(0x52) A3 A2 A1 A0             -> D3 D2 D1 D0 on ack
//     Any err or timeout                              -> 0x15
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   rx_dat/rx_stb       : incoming command byte and its one-cycle valid pulse
//   tx_dat/tx_stb       : outgoing response byte and its one-cycle send pulse
//   tx_busy             : transmitter busy; a byte is only sent while low
//   wb_*                : Wishbone master port (single 32-bit cycles)
// Parameters
//   timeout             : max cycles (2..65535) cyc/stb stay high without ack/err
module wb_dbg_master #(
  parameter int unsigned timeout = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_dat,
  input  logic        rx_stb,
  output logic [7:0]  tx_dat,
  output logic        tx_stb,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [7:0]  CMD_WR   = 8'h57;
  localparam logic [7:0]  CMD_RD   = 8'h52;
  localparam logic [7:0]  RSP_ACK  = 8'h06;
  localparam logic [7:0]  RSP_NAK  = 8'h15;
  localparam logic [15:0] TMO_LAST = 16'(timeout - 32'd1);

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic [15:0] bus_cnt_q, bus_cnt_d;
  logic        ok_q, ok_d;
  logic [2:0]  resp_cnt_q, resp_cnt_d;
  logic        gap_q, gap_d;
  logic        tx_stb_q, tx_stb_d;
  logic [7:0]  tx_dat_q, tx_dat_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;

  logic [2:0]  resp_len_s;
  logic [7:0]  resp_byte_s;

  // Response length and the byte due next, selected by the send counter.
  always_comb begin
    resp_len_s  = 3'd1;
    resp_byte_s = RSP_NAK;
    if (ok_q && !is_wr_q) begin
      resp_len_s = 3'd4;
      case (resp_cnt_q[1:0])
        2'd0:    resp_byte_s = rdat_q[31:24];
        2'd1:    resp_byte_s = rdat_q[23:16];
        2'd2:    resp_byte_s = rdat_q[15:8];
        2'd3:    resp_byte_s = rdat_q[7:0];
        default: resp_byte_s = RSP_NAK;
      endcase
    end else if (ok_q) begin
      resp_byte_s = RSP_ACK;
    end else begin
      resp_byte_s = RSP_NAK;
    end
  end

  // Next-state and datapath logic for frame parsing, bus cycle and response.
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    bus_cnt_d  = bus_cnt_q;
    ok_d       = ok_q;
    resp_cnt_d = resp_cnt_q;
    tx_stb_d   = 1'b0;
    tx_dat_d   = tx_dat_q;
    // The cycle after a tx_stb is a dead cycle so the transmitter can raise busy.
    gap_d      = tx_stb_q;

    case (state_q)
      IDLE: begin
        if (rx_stb && (rx_dat == CMD_WR || rx_dat == CMD_RD)) begin
          is_wr_d    = (rx_dat == CMD_WR);
          byte_cnt_d = 2'd0;
          state_d    = ADDR;
        end else begin
          state_d    = IDLE;
        end
      end
      ADDR: begin
        if (rx_stb) begin
          adr_d      = {adr_q[23:0], rx_dat};
          byte_cnt_d = byte_cnt_q + 2'd1;
          bus_cnt_d  = 16'd0;
          if (byte_cnt_q == 2'd3) begin
            state_d = is_wr_q ? DATA : BUS;
          end else begin
            state_d = ADDR;
          end
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (rx_stb) begin
          wdat_d     = {wdat_q[23:0], rx_dat};
          byte_cnt_d = byte_cnt_q + 2'd1;
          bus_cnt_d  = 16'd0;
          if (byte_cnt_q == 2'd3) begin
            state_d = BUS;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      BUS: begin
        // ack together with err counts as a failure.
        if (wb_ack_i && !wb_err_i) begin
          ok_d       = 1'b1;
          resp_cnt_d = 3'd0;
          state_d    = RESP;
          if (!is_wr_q) begin
            rdat_d = wb_dat_i;
          end else begin
            rdat_d = rdat_q;
          end
        end else if (wb_err_i || bus_cnt_q == TMO_LAST) begin
          ok_d       = 1'b0;
          resp_cnt_d = 3'd0;
          state_d    = RESP;
        end else begin
          bus_cnt_d  = bus_cnt_q + 16'd1;
        end
      end
      RESP: begin
        // Leave only once the final byte's strobe is on the wire.
        if (tx_stb_q && resp_cnt_q == resp_len_s) begin
          state_d = IDLE;
        end else if (!tx_stb_q && !gap_q && !tx_busy && resp_cnt_q < resp_len_s) begin
          tx_stb_d   = 1'b1;
          tx_dat_d   = resp_byte_s;
          resp_cnt_d = resp_cnt_q + 3'd1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus control is registered so it tracks the BUS state exactly.
    if (state_d == BUS) begin
      cyc_d = 1'b1;
      we_d  = is_wr_q;
      sel_d = 4'hF;
    end else begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      sel_d = 4'h0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
      adr_q      <= 32'd0;
      wdat_q     <= 32'd0;
      rdat_q     <= 32'd0;
      bus_cnt_q  <= 16'd0;
      ok_q       <= 1'b0;
      resp_cnt_q <= 3'd0;
      gap_q      <= 1'b0;
      tx_stb_q   <= 1'b0;
      tx_dat_q   <= 8'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      bus_cnt_q  <= bus_cnt_d;
      ok_q       <= ok_d;
      resp_cnt_q <= resp_cnt_d;
      gap_q      <= gap_d;
      tx_stb_q   <= tx_stb_d;
      tx_dat_q   <= tx_dat_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
    end
  end

  assign tx_stb   = tx_stb_q;
  assign tx_dat   = tx_dat_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_dbg_master.sv
// tb_wb_dbg_master
//   Directed bench for wb_dbg_master (timeout = 16). A single initial block
//   sends frames, plays the Wishbone slave and the byte transmitter, and
//   compares against hand-computed values.
module tb_wb_dbg_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic [7:0]  tx_dat;
  logic        tx_stb;
  logic        tx_busy;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_adr;
  logic [31:0] cap_dat;
  logic        cap_we;
  logic        cap_stb;
  logic [3:0]  cap_sel;
  int          bus_len;
  logic [7:0]  rb [8];
  int          rcount;
  bit          bviol;
  int          quiet;

  wb_dbg_master #(.timeout(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_dat   (rx_dat),
    .rx_stb   (rx_stb),
    .tx_dat   (tx_dat),
    .tx_stb   (tx_stb),
    .tx_busy  (tx_busy),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rx byte: valid for one full cycle, returns at the following negedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dat = b;
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
    send(8'h57);
    send(a[31:24]); send(a[23:16]); send(a[15:8]); send(a[7:0]);
    send(d[31:24]); send(d[23:16]); send(d[15:8]); send(d[7:0]);
  endtask

  task automatic send_rd(input logic [31:0] a);
    send(8'h52);
    send(a[31:24]); send(a[23:16]); send(a[15:8]); send(a[7:0]);
  endtask

  // Slave: mode 0 ack, 1 err, 2 ack+err, 3 never respond; response on the
  // cycle with index resp_at. Counts cycles with cyc high (bounded).
  task automatic run_bus(input int resp_at, input int mode, input logic [31:0] rdata,
                         input bit junk);
    bus_len = 0;
    while (wb_cyc_o === 1'b1 && bus_len < 100) begin
      if (bus_len == 0) begin
        cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_we = wb_we_o;
        cap_stb = wb_stb_o; cap_sel = wb_sel_o;
      end
      wb_dat_i = rdata;
      if (mode != 3 && bus_len == resp_at) begin
        wb_ack_i = (mode == 0 || mode == 2);
        wb_err_i = (mode == 1 || mode == 2);
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
      if (junk) begin
        rx_dat = 8'h57;
        rx_stb = 1'b1;
      end
      bus_len++;
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    rx_stb   = 1'b0;
  endtask

  // Transmitter: raises busy for busy_len cycles after each tx_stb and records bytes.
  task automatic get_resp(input int n, input int busy_len, input bit junk);
    int bc;
    bc = 0;
    rcount = 0;
    bviol = 1'b0;
    for (int i = 0; i < n * (busy_len + 4) + 20; i++) begin
      @(negedge clk);
      if (bc > 0) begin
        tx_busy = 1'b1;
        bc--;
      end else begin
        tx_busy = 1'b0;
      end
      if (tx_stb === 1'b1) begin
        if (rcount < 8) rb[rcount] = tx_dat;
        if (tx_busy) bviol = 1'b1;
        rcount++;
        bc = busy_len;
      end
      if (junk && rcount < n) begin
        rx_dat = 8'h52;
        rx_stb = 1'b1;
      end else begin
        rx_stb = 1'b0;
      end
    end
    tx_busy = 1'b0;
    rx_stb  = 1'b0;
  endtask

  // Counts cycles with any bus or tx activity over a window.
  task automatic watch_quiet(input int ncyc);
    quiet = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (wb_cyc_o !== 1'b0 || tx_stb !== 1'b0) quiet++;
    end
  endtask

  initial begin
    reset = 1'b1; rx_dat = 8'h00; rx_stb = 1'b0; tx_busy = 1'b0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_txstb", {31'd0, tx_stb}, 32'd0);
    chk("rst_txdat", {24'd0, tx_dat}, 32'd0);
    reset = 1'b0;

    // Write, zero-wait ack
    send_wr(32'h0000_1000, 32'hDEAD_BEEF);
    run_bus(0, 0, 32'h0, 1'b0);
    chk("wr_len", bus_len, 32'd1);
    chk("wr_we", {31'd0, cap_we}, 32'd1);
    chk("wr_stb", {31'd0, cap_stb}, 32'd1);
    chk("wr_sel", {28'd0, cap_sel}, 32'hF);
    chk("wr_adr", cap_adr, 32'h0000_1000);
    chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
    chk("wr_sel_after", {28'd0, wb_sel_o}, 32'd0);
    get_resp(1, 2, 1'b0);
    chk("wr_rcount", rcount, 32'd1);
    chk("wr_resp", {24'd0, rb[0]}, 32'h06);

    // Read with 3 wait states, transmitter busy 10 cycles per byte
    send_rd(32'h4000_0004);
    run_bus(3, 0, 32'h1234_5678, 1'b0);
    chk("rd_len", bus_len, 32'd4);
    chk("rd_we", {31'd0, cap_we}, 32'd0);
    chk("rd_adr", cap_adr, 32'h4000_0004);
    get_resp(4, 10, 1'b0);
    chk("rd_rcount", rcount, 32'd4);
    chk("rd_b0", {24'd0, rb[0]}, 32'h12);
    chk("rd_b1", {24'd0, rb[1]}, 32'h34);
    chk("rd_b2", {24'd0, rb[2]}, 32'h56);
    chk("rd_b3", {24'd0, rb[3]}, 32'h78);
    chk("rd_busy_viol", {31'd0, bviol}, 32'd0);

    // Timeout: no ack ever
    send_rd(32'h0000_0008);
    run_bus(0, 3, 32'h0, 1'b0);
    chk("tmo_len", bus_len, 32'd16);
    get_resp(1, 2, 1'b0);
    chk("tmo_rcount", rcount, 32'd1);
    chk("tmo_resp", {24'd0, rb[0]}, 32'h15);
    send_rd(32'h0000_000C);
    run_bus(1, 0, 32'hCAFE_F00D, 1'b0);
    chk("post_tmo_len", bus_len, 32'd2);
    get_resp(4, 3, 1'b0);
    chk("post_tmo_rcount", rcount, 32'd4);
    chk("post_tmo_b0", {24'd0, rb[0]}, 32'hCA);
    chk("post_tmo_b3", {24'd0, rb[3]}, 32'h0D);

    // Garbage bytes, then a write that gets err
    send(8'h00);
    send(8'hFF);
    send_wr(32'h0000_0020, 32'h1122_3344);
    run_bus(0, 1, 32'h0, 1'b0);
    chk("err_len", bus_len, 32'd1);
    chk("err_adr", cap_adr, 32'h0000_0020);
    chk("err_we", {31'd0, cap_we}, 32'd1);
    get_resp(1, 2, 1'b0);
    chk("err_rcount", rcount, 32'd1);
    chk("err_resp", {24'd0, rb[0]}, 32'h15);

    // ack and err together
    send_rd(32'h0000_0024);
    run_bus(1, 2, 32'h5555_AAAA, 1'b0);
    chk("ackerr_len", bus_len, 32'd2);
    get_resp(1, 2, 1'b0);
    chk("ackerr_rcount", rcount, 32'd1);
    chk("ackerr_resp", {24'd0, rb[0]}, 32'h15);

    // Overrun: junk bytes during BUS and RESP are dropped
    send_rd(32'h0000_0030);
    run_bus(2, 0, 32'hA5A5_5A5A, 1'b1);
    chk("ovr_len", bus_len, 32'd3);
    get_resp(4, 2, 1'b1);
    chk("ovr_rcount", rcount, 32'd4);
    chk("ovr_b0", {24'd0, rb[0]}, 32'hA5);
    chk("ovr_b2", {24'd0, rb[2]}, 32'h5A);
    send_wr(32'h0000_0034, 32'h0102_0304);
    run_bus(0, 0, 32'h0, 1'b0);
    chk("ovr_next_len", bus_len, 32'd1);
    chk("ovr_next_adr", cap_adr, 32'h0000_0034);
    chk("ovr_next_dat", cap_dat, 32'h0102_0304);
    get_resp(1, 2, 1'b0);
    chk("ovr_next_resp", {24'd0, rb[0]}, 32'h06);

    // Async reset mid-address: address register is nonzero before reset
    send(8'h52);
    send(8'hAB);
    send(8'hCD);
    #2 reset = 1'b1;
    #1;
    chk("arst_addr_adr", wb_adr_o, 32'd0);
    chk("arst_addr_dat", wb_dat_o, 32'd0);
    chk("arst_addr_txdat", {24'd0, tx_dat}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_quiet(20);
    chk("arst_addr_quiet", quiet, 32'd0);

    // Async reset with cyc high
    send_rd(32'h0000_0040);
    chk("arst_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("arst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("arst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("arst_adr", wb_adr_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_quiet(20);
    chk("arst_cyc_quiet", quiet, 32'd0);

    // Fresh frame after reset
    send_rd(32'h0000_0044);
    run_bus(0, 0, 32'h0BAD_BEEF, 1'b0);
    chk("fresh_len", bus_len, 32'd1);
    chk("fresh_adr", cap_adr, 32'h0000_0044);
    get_resp(4, 1, 1'b0);
    chk("fresh_rcount", rcount, 32'd4);
    chk("fresh_b0", {24'd0, rb[0]}, 32'h0B);
    chk("fresh_b1", {24'd0, rb[1]}, 32'hAD);
    chk("fresh_b3", {24'd0, rb[3]}, 32'hEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
